// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing
// Description : Raster timing generator for the VGA controller. Produces
//               pixel/line position counters, sync/blank decode, line and
//               frame strobes and a free-running frame counter. Everything
//               is registered and advances only on pixel clock-enable.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing #(
    parameter int H_VIEW     = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VIEW     = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int HW         = 10,
    parameter int VW         = 10,
    parameter int FW         = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    output logic [HW-1:0] hpos,
    output logic [VW-1:0] vpos,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank,
    output logic          visible,
    output logic          line_start,
    output logic          frame_start,
    output logic [FW-1:0] frame_count
);

    // ------------------------------------------------------------------
    // Derived geometry
    // ------------------------------------------------------------------
    localparam int c_h_total = H_VIEW + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total = V_VIEW + V_FRONT + V_SYNC + V_BACK;

    localparam logic [HW-1:0] c_h_last     = HW'(c_h_total - 1);
    localparam logic [HW-1:0] c_h_view     = HW'(H_VIEW);
    localparam logic [HW-1:0] c_hs_start   = HW'(H_VIEW + H_FRONT);
    localparam logic [HW-1:0] c_hs_end     = HW'(H_VIEW + H_FRONT + H_SYNC);

    localparam logic [VW-1:0] c_v_last     = VW'(c_v_total - 1);
    localparam logic [VW-1:0] c_v_view     = VW'(V_VIEW);
    localparam logic [VW-1:0] c_vs_start   = VW'(V_VIEW + V_FRONT);
    localparam logic [VW-1:0] c_vs_end     = VW'(V_VIEW + V_FRONT + V_SYNC);

    // Active levels of the sync outputs
    localparam logic c_hs_on = (H_SYNC_POL != 0);
    localparam logic c_vs_on = (V_SYNC_POL != 0);

    // Every porch/sync field must be non-empty and the totals must fit the
    // counter widths. A non-zero back porch also guarantees that the sync
    // end positions are representable at HW/VW width.
    localparam bit c_params_ok =
        (H_VIEW > 0) && (H_FRONT > 0) && (H_SYNC > 0) && (H_BACK > 0) &&
        (V_VIEW > 0) && (V_FRONT > 0) && (V_SYNC > 0) && (V_BACK > 0) &&
        (HW > 0) && (VW > 0) && (FW > 0) &&
        (c_h_total <= (1 << HW)) && (c_v_total <= (1 << VW));

    generate
        if (!c_params_ok) begin : g_bad_params
            $error("vga_timing: illegal timing parameter set");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [HW-1:0] r_hpos;
    logic [VW-1:0] r_vpos;
    logic [FW-1:0] r_frame_count;
    logic          r_first_wrap;   // set until the first wrap out of reset
    logic          r_hsync;
    logic          r_vsync;
    logic          r_hblank;
    logic          r_vblank;
    logic          r_visible;
    logic          r_line_start;
    logic          r_frame_start;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic [HW-1:0] w_hpos_nxt;
    logic [VW-1:0] w_vpos_nxt;
    logic [FW-1:0] w_frame_count_nxt;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_hblank_nxt;
    logic          w_vblank_nxt;
    logic          w_line_start_nxt;
    logic          w_frame_start_nxt;

    // Next raster position and its decode; decoding the next position lets
    // the registered outputs line up with the registered counters.
    always_comb begin
        w_h_wrap   = (r_hpos == c_h_last);
        w_v_wrap   = (r_vpos == c_v_last);

        w_hpos_nxt = w_h_wrap ? '0 : r_hpos + 1'b1;

        w_vpos_nxt = r_vpos;
        if (w_h_wrap) begin
            w_vpos_nxt = w_v_wrap ? '0 : r_vpos + 1'b1;
        end

        // The wrap leaving reset lands on (0,0) but is not a completed frame
        w_frame_count_nxt = r_frame_count;
        if (w_h_wrap && w_v_wrap && !r_first_wrap) begin
            w_frame_count_nxt = r_frame_count + 1'b1;
        end

        w_hs_act          = (w_hpos_nxt >= c_hs_start) && (w_hpos_nxt < c_hs_end);
        w_vs_act          = (w_vpos_nxt >= c_vs_start) && (w_vpos_nxt < c_vs_end);
        w_hblank_nxt      = (w_hpos_nxt >= c_h_view);
        w_vblank_nxt      = (w_vpos_nxt >= c_v_view);
        w_line_start_nxt  = (w_hpos_nxt == '0);
        w_frame_start_nxt = (w_hpos_nxt == '0) && (w_vpos_nxt == '0);
    end

    // Counter and output registers; reset parks on the last pixel of a frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hpos        <= c_h_last;
            r_vpos        <= c_v_last;
            r_frame_count <= '0;
            r_first_wrap  <= 1'b1;
            r_hsync       <= ~c_hs_on;
            r_vsync       <= ~c_vs_on;
            r_hblank      <= 1'b1;
            r_vblank      <= 1'b1;
            r_visible     <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (ce) begin
            r_hpos        <= w_hpos_nxt;
            r_vpos        <= w_vpos_nxt;
            r_frame_count <= w_frame_count_nxt;
            r_first_wrap  <= 1'b0;
            r_hsync       <= w_hs_act ? c_hs_on : ~c_hs_on;
            r_vsync       <= w_vs_act ? c_vs_on : ~c_vs_on;
            r_hblank      <= w_hblank_nxt;
            r_vblank      <= w_vblank_nxt;
            r_visible     <= ~w_hblank_nxt & ~w_vblank_nxt;
            r_line_start  <= w_line_start_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

    assign hpos        = r_hpos;
    assign vpos        = r_vpos;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign hblank      = r_hblank;
    assign vblank      = r_vblank;
    assign visible     = r_visible;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Upstream stage of the VGA controller. Generates raster position counters and the sync and blank timing the controller consumes (hsync, vsync, hblank, vblank) plus the pixel position used to compute r/g/b.
- Fully parameterised for porch and sync geometry. Defaults are 640x480@60 with a 25.175 MHz pixel clock.
- Adds a pixel clock-enable, line/frame strobes and a free-running frame counter for animation.

Parameters:
- H_VIEW, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VIEW, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, active level of hsync (0 = active-low)
- V_SYNC_POL, 0, active level of vsync (0 = active-low)
- HW, 10, width of hpos; must hold H_TOTAL-1
- VW, 10, width of vpos; must hold V_TOTAL-1
- FW, 8, width of frame_count

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  synchronous, active-low reset
- ce  input  1  pixel advance enable; counters step only when ce=1
- hpos  output  HW  current pixel column, 0..H_TOTAL-1
- vpos  output  VW  current line, 0..V_TOTAL-1
- hsync  output  1  horizontal sync at H_SYNC_POL level when active
- vsync  output  1  vertical sync at V_SYNC_POL level when active
- hblank  output  1  1 when hpos >= H_VIEW
- vblank  output  1  1 when vpos >= V_VIEW
- visible  output  1  ~hblank & ~vblank
- line_start  output  1  1 for the single ce-cycle in which hpos==0
- frame_start  output  1  1 for the single ce-cycle in which hpos==0 and vpos==0
- frame_count  output  FW  number of completed frames, modulo 2^FW

Behaviour:
- Derived constants:
  - H_TOTAL = H_VIEW+H_FRONT+H_SYNC+H_BACK (default 800)
  - V_TOTAL = V_VIEW+V_FRONT+V_SYNC+V_BACK (default 525)
- Clock and reset: one clock. Reset is synchronous and active-low: on any rising clk edge with rst_n=0, all state is loaded, regardless of ce.
- Reset state is the last pixel of a frame:
  - hpos=H_TOTAL-1, vpos=V_TOTAL-1, frame_count=0
  - hblank=1, vblank=1, visible=0
  - hsync=~H_SYNC_POL, vsync=~V_SYNC_POL (inactive)
  - line_start=0, frame_start=0
- First edge after release: the first rising edge with rst_n=1 and ce=1 moves to hpos=0, vpos=0 and raises frame_start and line_start. frame_count stays 0 on this wrap out of reset.
- Counting, on each edge with rst_n=1 and ce=1:
  - hpos increments; when it was H_TOTAL-1 it wraps to 0 and vpos increments.
  - When vpos was V_TOTAL-1 on that same wrap, vpos wraps to 0 and frame_count increments. The only exception is the first wrap after reset.
- ce=0: hpos, vpos, frame_count and all outputs hold. line_start and frame_start are also held, so each pulse spans exactly one ce-qualified pixel.
- All outputs are registered and always consistent with the registered hpos/vpos in the same cycle: zero latency between position and its decoded signals, and no combinational glitches.
- Decode rules:
  - hsync is active iff H_VIEW+H_FRONT <= hpos < H_VIEW+H_FRONT+H_SYNC (default 656..751).
  - vsync is active iff V_VIEW+V_FRONT <= vpos < V_VIEW+V_FRONT+V_SYNC (default 490..491).
  - hblank is 1 iff hpos >= H_VIEW; vblank is 1 iff vpos >= V_VIEW.
- Decode computation: outputs are computed from next-state values and registered with the counters. Compares are unsigned at HW/VW width.
- frame_count wraps 2^FW-1 -> 0 silently.
- Reset mid-frame: the next edge with rst_n=0 forces the reset state immediately. Any in-progress sync pulse is truncated, with no extra cycles.
- ce and rst_n both low: reset wins.
- Illegal parameter sets (H_TOTAL > 2^HW, V_TOTAL > 2^VW, or any zero-width field) are a compile-time error via generate-time check.

Test Plan:
- Hold rst_n=0 for 3 cycles with ce=1 -> hpos=799, vpos=524, hblank=vblank=1, visible=0, hsync=vsync=1, frame_count=0, strobes 0. Release -> next edge hpos=0, vpos=0, visible=1, frame_start=line_start=1, frame_count=0.
- Run one line with ce=1 -> hsync=0 exactly for hpos 656..751 (96 cycles); hblank rises at hpos=640. At hpos=799->0, vpos increments and line_start pulses for 1 cycle.
- Run a full frame -> vsync=0 only for vpos 490..491; vblank=1 for vpos 480..524. frame_start and frame_count=1 after exactly 800*525=420000 cycles from the first (0,0).
- Toggle ce 1/0 every cycle -> counters advance every other cycle, frame period 840000 clocks, each strobe high for 2 clocks. Outputs are constant while ce=0.
- Force frame_count wrap with FW=2 -> after 4 frames frame_count goes 3->0 with no other disturbance.
- Assert rst_n=0 at hpos=700, vpos=490 (both syncs active) -> next edge hsync=vsync=1 and hpos=799, vpos=524. After release, frame restarts at (0,0).
